// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with registered one-cycle match pulse.
// Define SEQDET_GAP_TIMEOUT_EN to discard a partial match after TIMEOUT idle cycles.
module seq_detect_prog #(
   parameter int unsigned         MAX_LEN     = 8,
   parameter int unsigned         CNT_W       = 8,
   parameter logic [MAX_LEN-1:0]  RST_PATTERN = MAX_LEN'(4'b1101),
   parameter int unsigned         RST_LEN     = 4,
   parameter bit                  RST_OVERLAP = 1'b0,
   parameter int unsigned         TIMEOUT     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [3:0]         cfg_len,
   input  logic               cfg_overlap,
   input  logic               count_clr,
   input  logic               seq_valid,
   input  logic               seq_in,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err,
   output logic [3:0]         fill
);

   typedef enum logic [1:0] {StIdle, StHunt, StHit} state_t;

   localparam bit               RST_LEGAL = (RST_LEN >= 2) && (RST_LEN <= MAX_LEN);
   localparam logic [3:0]       RST_LEN4  = 4'(RST_LEN);
   localparam logic [3:0]       MAX_LEN4  = 4'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [3:0]         fill_q, fill_d;
   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [3:0]         len_q, len_d;
   logic               overlap_q, overlap_d;
   logic               cfg_err_q, cfg_err_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] hist_n;
   logic [4:0]         fill_inc;
   logic [3:0]         fill_n;
   logic               hit;
   logic               cfg_legal;

`ifdef SEQDET_GAP_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
   logic [IDLE_W-1:0] idle_q, idle_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   // Compare only the low len_q bits of the shifted history against the pattern.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (4'(i) < len_q);
      end
      hist_n   = {hist_q[MAX_LEN-2:0], seq_in};
      fill_inc = {1'b0, fill_q} + 5'd1;
      fill_n   = (fill_inc > {1'b0, len_q}) ? len_q : fill_inc[3:0];
      hit      = (fill_n == len_q) && (((hist_n ^ pattern_q) & mask) == '0);
      cfg_legal = (cfg_len >= 4'd2) && (cfg_len <= MAX_LEN4);
   end

   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      cfg_err_d = cfg_err_q;
`ifdef SEQDET_GAP_TIMEOUT_EN
      idle_d    = '0;
`endif
      if (cfg_load) begin
         pattern_d = cfg_pattern;
         len_d     = cfg_len;
         overlap_d = cfg_overlap;
         hist_d    = '0;
         fill_d    = '0;
         cfg_err_d = ~cfg_legal;
         state_d   = cfg_legal ? StHunt : StIdle;
      end else if (state_q != StIdle) begin
         if (seq_valid) begin
            hist_d = hist_n;
            if (hit) begin
               state_d = StHit;
               fill_d  = overlap_q ? fill_n : 4'd0;
            end else begin
               state_d = StHunt;
               fill_d  = fill_n;
            end
         end else begin
            state_d = StHunt;
`ifdef SEQDET_GAP_TIMEOUT_EN
            if (fill_q != '0) begin
               if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                  hist_d = '0;
                  fill_d = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
`endif
         end
      end
   end

   // Clear wins over the increment from a match in the same cycle.
   always_comb begin
      count_d = count_q;
      if (count_clr) begin
         count_d = '0;
      end else if ((state_q == StHit) && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RST_LEGAL ? StHunt : StIdle;
         hist_q    <= '0;
         fill_q    <= '0;
         pattern_q <= RST_PATTERN;
         len_q     <= RST_LEN4;
         overlap_q <= RST_OVERLAP;
         cfg_err_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         cfg_err_q <= cfg_err_d;
         count_q   <= count_d;
      end
   end

`ifdef SEQDET_GAP_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`endif

   assign match       = (state_q == StHit);
   assign match_count = count_q;
   assign cfg_err     = cfg_err_q;
   assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_seq_detect_prog;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned TIMEOUT = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               cfg_load = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [3:0]         cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic               count_clr = 1'b0;
   logic               seq_valid = 1'b0;
   logic               seq_in = 1'b0;
   logic               match;
   logic [CNT_W-1:0]   match_count;
   logic               cfg_err;
   logic [3:0]         fill;

   always #5 clk = ~clk;

   seq_detect_prog #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .count_clr   (count_clr),
      .seq_valid   (seq_valid),
      .seq_in      (seq_in),
      .match       (match),
      .match_count (match_count),
      .cfg_err     (cfg_err),
      .fill        (fill)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: queue of bits received since the last clear.
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ov, m_legal, m_match, m_err;
   int         m_cnt;
   int         m_idle;
   bit         m_q[$];

   function automatic bit tail_matches();
      int n = m_q.size();
      if (n < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++) begin
         if (m_q[n - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_pat = 8'b0000_1101; m_len = 4; m_ov = 0; m_legal = 1;
      m_match = 0; m_err = 0; m_cnt = 0; m_idle = 0;
      m_q.delete();
   endtask

   task automatic model_edge(input bit ld, input logic [7:0] pat, input int len, input bit ov,
                             input bit clr, input bit v, input bit b);
      bit prev = m_match;
      if (clr) m_cnt = 0;
      else if (prev && m_cnt < CNT_MAX) m_cnt++;
      if (ld) begin
         m_pat = pat; m_len = len; m_ov = ov;
         m_legal = (len >= 2) && (len <= MAX_LEN);
         m_err = !m_legal; m_match = 0; m_idle = 0;
         m_q.delete();
      end else if (m_legal && v) begin
         m_q.push_back(b);
         m_idle = 0;
         m_match = tail_matches();
         if (m_match && !m_ov) m_q.delete();
         while (m_q.size() > m_len) void'(m_q.pop_front());
      end else begin
         m_match = 0;
`ifdef SEQDET_GAP_TIMEOUT_EN
         if (m_legal && m_q.size() != 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_q.delete();
               m_idle = 0;
            end
         end else begin
            m_idle = 0;
         end
`endif
      end
   endtask

   task automatic step(input bit ld, input logic [7:0] pat, input int len, input bit ov,
                       input bit clr, input bit v, input bit b);
      cfg_load = ld; cfg_pattern = pat; cfg_len = 4'(len); cfg_overlap = ov;
      count_clr = clr; seq_valid = v; seq_in = b;
      @(posedge clk);
      model_edge(ld, pat, len, ov, clr, v, b);
      #1;
   endtask

   task automatic bit_in(input bit b);
      step(0, 8'h00, 0, 0, 0, 1, b);
   endtask

   task automatic idle_cyc();
      step(0, 8'h00, 0, 0, 0, 0, 0);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_match"}, int'(match), int'(m_match));
      check({tag, "_count"}, int'(match_count), m_cnt);
      check({tag, "_err"}, int'(cfg_err), int'(m_err));
      check({tag, "_fill"}, int'(fill), m_q.size());
   endtask

   task automatic do_reset(input string tag);
      cfg_load = 0; count_clr = 0; seq_valid = 0; seq_in = 0;
      reset = 1'b1;
      #2;
      model_reset();
      check({tag, "_match"}, int'(match), 0);
      check({tag, "_count"}, int'(match_count), 0);
      check({tag, "_err"}, int'(cfg_err), 0);
      check({tag, "_fill"}, int'(fill), 0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   typedef struct {
      bit         ld;
      logic [7:0] pat;
      int         len;
      bit         ov;
      bit         clr;
      bit         v;
      bit         b;
      bit         m;
      int         cnt;
      bit         err;
      int         fill;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t bv(bit b, bit m, int cnt, bit err, int f);
      vec_t r = '{0, 8'h00, 0, 0, 0, 1, b, m, cnt, err, f};
      return r;
   endfunction

   function automatic vec_t iv(bit clr, bit m, int cnt, bit err, int f);
      vec_t r = '{0, 8'h00, 0, 0, clr, 0, 0, m, cnt, err, f};
      return r;
   endfunction

   // Load row also presents a valid bit, which must be discarded.
   function automatic vec_t lv(logic [7:0] pat, int len, bit ov, bit clr, int cnt, bit err);
      vec_t r = '{1, pat, len, ov, clr, 1, 1, 0, cnt, err, 0};
      return r;
   endfunction

   initial begin
      // Reset config "1101", non-overlap, bits 1101101
      tbl.push_back(bv(1, 0, 0, 0, 1)); tbl.push_back(bv(1, 0, 0, 0, 2));
      tbl.push_back(bv(0, 0, 0, 0, 3)); tbl.push_back(bv(1, 1, 0, 0, 0));
      tbl.push_back(bv(1, 0, 1, 0, 1)); tbl.push_back(bv(0, 0, 1, 0, 2));
      tbl.push_back(bv(1, 0, 1, 0, 3)); tbl.push_back(iv(0, 0, 1, 0, 3));
      // "1101" overlapping, count cleared with the load
      tbl.push_back(lv(8'b1101, 4, 1, 1, 0, 0));
      tbl.push_back(bv(1, 0, 0, 0, 1)); tbl.push_back(bv(1, 0, 0, 0, 2));
      tbl.push_back(bv(0, 0, 0, 0, 3)); tbl.push_back(bv(1, 1, 0, 0, 4));
      tbl.push_back(bv(1, 0, 1, 0, 4)); tbl.push_back(bv(0, 0, 1, 0, 4));
      tbl.push_back(bv(1, 1, 1, 0, 4)); tbl.push_back(iv(0, 0, 2, 0, 4));
      // "11" overlapping: three back-to-back pulses
      tbl.push_back(lv(8'b11, 2, 1, 1, 0, 0));
      tbl.push_back(bv(1, 0, 0, 0, 1)); tbl.push_back(bv(1, 1, 0, 0, 2));
      tbl.push_back(bv(1, 1, 1, 0, 2)); tbl.push_back(bv(1, 1, 2, 0, 2));
      tbl.push_back(iv(0, 0, 3, 0, 2));
      // "11" non-overlapping
      tbl.push_back(lv(8'b11, 2, 0, 1, 0, 0));
      tbl.push_back(bv(1, 0, 0, 0, 1)); tbl.push_back(bv(1, 1, 0, 0, 0));
      tbl.push_back(bv(1, 0, 1, 0, 1)); tbl.push_back(bv(1, 1, 1, 0, 0));
      tbl.push_back(iv(0, 0, 2, 0, 0));
      // Illegal lengths 0 and 9, then a legal reload
      tbl.push_back(lv(8'b11, 0, 1, 0, 2, 1));
      tbl.push_back(bv(1, 0, 2, 1, 0)); tbl.push_back(bv(1, 0, 2, 1, 0));
      tbl.push_back(lv(8'hFF, 9, 1, 0, 2, 1));
      tbl.push_back(bv(1, 0, 2, 1, 0)); tbl.push_back(bv(1, 0, 2, 1, 0));
      tbl.push_back(lv(8'b1101, 4, 0, 0, 2, 0));
      // count_clr in the match cycle beats the increment
      tbl.push_back(bv(1, 0, 2, 0, 1)); tbl.push_back(bv(1, 0, 2, 0, 2));
      tbl.push_back(bv(0, 0, 2, 0, 3)); tbl.push_back(bv(1, 1, 2, 0, 0));
      tbl.push_back(iv(1, 0, 0, 0, 0));

      do_reset("rst0");

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ov, tbl[i].clr, tbl[i].v, tbl[i].b);
         check($sformatf("tbl%0d_match", i), int'(match), int'(tbl[i].m));
         check($sformatf("tbl%0d_count", i), int'(match_count), tbl[i].cnt);
         check($sformatf("tbl%0d_err", i), int'(cfg_err), int'(tbl[i].err));
         check($sformatf("tbl%0d_fill", i), int'(fill), tbl[i].fill);
      end

      // Gap of 10 idle cycles inside "1101"
      bit_in(1); bit_in(1); bit_in(0);
      for (int i = 0; i < 10; i++) begin
         idle_cyc();
         check_model($sformatf("gap%0d", i));
`ifdef SEQDET_GAP_TIMEOUT_EN
         if (i == 3) check("gap_timeout_fill", int'(fill), 0);
`else
         if (i == 3) check("gap_hold_fill", int'(fill), 3);
`endif
      end
      bit_in(1);
`ifdef SEQDET_GAP_TIMEOUT_EN
      check("gap_timeout_match", int'(match), 0);
`else
      check("gap_hold_match", int'(match), 1);
`endif
      idle_cyc();

      // Reset in the middle of a partial match restores the reset config
      step(1, 8'b011, 3, 1, 0, 0, 0);
      bit_in(1); bit_in(1); bit_in(0);
      do_reset("rst_mid");
      bit_in(1);
      check("rst_mid_match", int'(match), 0);
      check("rst_mid_fill", int'(fill), 1);
      bit_in(1); bit_in(0); bit_in(1);
      check("rst_cfg_match", int'(match), 1);
      check_model("rst_cfg");

      // Saturation of match_count
      step(1, 8'b11, 2, 1, 1, 0, 0);
      for (int i = 0; i < 300; i++) bit_in(1);
      idle_cyc();
      check("sat_count", int'(match_count), CNT_MAX);
      check_model("sat");

      // Randomized traffic against the model
      step(1, 8'b1101, 4, 0, 1, 0, 0);
      for (int i = 0; i < 2000; i++) begin
         bit         ld  = ($urandom_range(0, 63) == 0);
         logic [7:0] pat = 8'($urandom());
         int         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10))
                                                       : int'($urandom_range(2, 4));
         bit         ov  = 1'($urandom());
         bit         clr = ($urandom_range(0, 49) == 0);
         bit         v   = ($urandom_range(0, 3) != 0);
         bit         b   = 1'($urandom());
         step(ld, pat, len, ov, clr, v, b);
         check_model($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
